// File: rtl/ot_pkg.sv
// Shared types for the colour box tracker: RGB565 field layout, report FSM states, box report record.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package ot_pkg;

    localparam int PIX_W = 16;
    localparam int R_W   = 5;
    localparam int G_W   = 6;
    localparam int B_W   = 5;
    localparam int R_LSB = 11;
    localparam int G_LSB = 5;
    localparam int B_LSB = 0;

    // Report fields are sized for the widest supported instance; narrower
    // instances zero-extend into them.
    localparam int BOX_XY_W  = 16;
    localparam int BOX_CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_FRAME,
        ST_REPORT
    } ot_state_t;

    typedef struct packed {
        logic [BOX_XY_W-1:0]  x_min;
        logic [BOX_XY_W-1:0]  x_max;
        logic [BOX_XY_W-1:0]  y_min;
        logic [BOX_XY_W-1:0]  y_max;
        logic [BOX_CNT_W-1:0] count;
        logic                 found;
    } box_rpt_t;

    // Inclusive per-channel window test; an inverted window (min > max) can never match.
    function automatic logic in_window(
        input logic [PIX_W-1:0] pix,
        input logic [R_W-1:0]   r_min,
        input logic [R_W-1:0]   r_max,
        input logic [G_W-1:0]   g_min,
        input logic [G_W-1:0]   g_max,
        input logic [B_W-1:0]   b_min,
        input logic [B_W-1:0]   b_max
    );
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
        r = pix[R_LSB +: R_W];
        g = pix[G_LSB +: G_W];
        b = pix[B_LSB +: B_W];
        return (r >= r_min) && (r <= r_max) &&
               (g >= g_min) && (g <= g_max) &&
               (b >= b_min) && (b <= b_max);
    endfunction

endpackage

// File: rtl/ot_byte_packer.sv
// Packs pairs of CMOS bytes into RGB565 pixels and delays the syncs to match.
// Latency: pixel valid one cycle after the edge sampling its second byte; syncs delayed one cycle.
// Backpressure: none; free-running stream, an odd trailing byte of a line is dropped.
module ot_byte_packer
    import ot_pkg::*;
#(
    parameter int BYTE_SWAP = 0
) (
    input  logic             core_clk,
    input  logic             arst_n,
    input  logic             href,
    input  logic             vsync,
    input  logic [7:0]       byte_dat,
    output logic [PIX_W-1:0] pix_dat,
    output logic             pix_vld,
    output logic             href_dly,
    output logic             vsync_dly
);

    logic       phase;
    logic [7:0] held_byte;

    // Byte-phase tracking, first-byte hold, pixel assembly and sync delay.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            phase     <= 1'b0;
            held_byte <= '0;
            pix_dat   <= '0;
            pix_vld   <= 1'b0;
            href_dly  <= 1'b0;
            vsync_dly <= 1'b0;
        end else begin
            href_dly  <= href;
            vsync_dly <= vsync;
            pix_vld   <= href & phase;
            phase     <= href ? ~phase : 1'b0;
            if (href && !phase) begin
                held_byte <= byte_dat;
            end
            if (href && phase) begin
                pix_dat <= (BYTE_SWAP != 0) ? {byte_dat, held_byte} : {held_byte, byte_dat};
            end
        end
    end

endmodule

// File: rtl/ot_color_box_tracker.sv
// Colour-window pixel marker with per-frame bounding box / match count report.
// Latency: pixel outputs one cycle after packer output; report strobe the cycle after vsync is first seen high.
// Backpressure: none; stream in, report strobe out, report fields hold until the next report.
module ot_color_box_tracker
    import ot_pkg::*;
#(
    parameter int X_W       = 11,
    parameter int Y_W       = 11,
    parameter int CNT_W     = 20,
    parameter int BYTE_SWAP = 0,
    parameter int MIN_COUNT = 64
) (
    input  logic             i_cmos_pclk_gbuf,
    input  logic             i_rst_n,
    input  logic             i_cmos_vsync_delay,
    input  logic             i_cmos_href_delay,
    input  logic [7:0]       i_cmos_d_delay,
    input  logic [R_W-1:0]   i_r_min,
    input  logic [R_W-1:0]   i_r_max,
    input  logic [G_W-1:0]   i_g_min,
    input  logic [G_W-1:0]   i_g_max,
    input  logic [B_W-1:0]   i_b_min,
    input  logic [B_W-1:0]   i_b_max,
    output logic             o_vsync,
    output logic             o_href,
    output logic [PIX_W-1:0] o_pix,
    output logic             o_pix_en,
    output logic             o_mask,
    output logic [X_W-1:0]   o_x,
    output logic [Y_W-1:0]   o_y,
    output logic             o_box_valid,
    output logic [X_W-1:0]   o_x_min,
    output logic [X_W-1:0]   o_x_max,
    output logic [Y_W-1:0]   o_y_min,
    output logic [Y_W-1:0]   o_y_max,
    output logic [CNT_W-1:0] o_count,
    output logic             o_found
);

    logic [PIX_W-1:0] pk_pix;
    logic             pk_vld;
    logic             pk_href;
    logic             pk_vsync;

    ot_byte_packer #(.BYTE_SWAP(BYTE_SWAP)) u_packer (
        .core_clk  (i_cmos_pclk_gbuf),
        .arst_n    (i_rst_n),
        .href      (i_cmos_href_delay),
        .vsync     (i_cmos_vsync_delay),
        .byte_dat  (i_cmos_d_delay),
        .pix_dat   (pk_pix),
        .pix_vld   (pk_vld),
        .href_dly  (pk_href),
        .vsync_dly (pk_vsync)
    );

    // pk_vsync is the raw vsync one cycle late, so it doubles as the edge-detect history.
    logic vsync_rise, vsync_fall, line_fall, frame_rise;
    assign vsync_rise = i_cmos_vsync_delay & ~pk_vsync;
    assign vsync_fall = ~i_cmos_vsync_delay & pk_vsync;
    // Coordinate edges are taken in the packer-output timeline so trailing pixels are counted first.
    assign line_fall  = ~pk_href & o_href;
    assign frame_rise = pk_vsync & ~o_vsync;

    logic [R_W-1:0] r_min_s, r_max_s;
    logic [G_W-1:0] g_min_s, g_max_s;
    logic [B_W-1:0] b_min_s, b_max_s;

    // Window snapshot at frame start so a frame is judged against one consistent window.
    always_ff @(posedge i_cmos_pclk_gbuf or negedge i_rst_n) begin
        if (!i_rst_n) begin
            {r_min_s, r_max_s, g_min_s, g_max_s, b_min_s, b_max_s} <= '0;
        end else if (vsync_fall) begin
            {r_min_s, r_max_s, g_min_s, g_max_s, b_min_s, b_max_s} <=
                {i_r_min, i_r_max, i_g_min, i_g_max, i_b_min, i_b_max};
        end
    end

    logic win_ok;
    assign win_ok = in_window(pk_pix, r_min_s, r_max_s, g_min_s, g_max_s, b_min_s, b_max_s);

    logic [X_W-1:0] x_cnt;
    logic [Y_W-1:0] y_cnt;
    logic           line_has_pix;

    // Column/row counters; rows only advance for lines that actually produced a pixel.
    always_ff @(posedge i_cmos_pclk_gbuf or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_cnt        <= '0;
            y_cnt        <= '0;
            line_has_pix <= 1'b0;
        end else begin
            if (pk_vld) begin
                x_cnt <= x_cnt + X_W'(1);
            end else if (!pk_href) begin
                x_cnt <= '0;
            end
            if (frame_rise) begin
                y_cnt        <= '0;
                line_has_pix <= 1'b0;
            end else if (line_fall && line_has_pix) begin
                y_cnt        <= y_cnt + Y_W'(1);
                line_has_pix <= 1'b0;
            end else if (pk_vld) begin
                line_has_pix <= 1'b1;
            end
        end
    end

    // Registered pixel stream outputs with syncs aligned to o_pix_en.
    always_ff @(posedge i_cmos_pclk_gbuf or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pix    <= '0;
            o_pix_en <= 1'b0;
            o_mask   <= 1'b0;
            o_x      <= '0;
            o_y      <= '0;
            o_href   <= 1'b0;
            o_vsync  <= 1'b0;
        end else begin
            o_pix_en <= pk_vld;
            o_mask   <= pk_vld & win_ok;
            o_href   <= pk_href;
            o_vsync  <= pk_vsync;
            if (pk_vld) begin
                o_pix <= pk_pix;
                o_x   <= x_cnt;
                o_y   <= y_cnt;
            end
        end
    end

    ot_state_t state, state_nx;
    logic      rpt_fire;
    logic      acc_en;
    assign acc_en = (state == ST_ARMED) || (state == ST_FRAME);

    // Report sequencing: arm at the first frame start, report on each vsync rise thereafter.
    always_ff @(posedge i_cmos_pclk_gbuf or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and report-fire decode.
    always_comb begin
        state_nx = state;
        rpt_fire = 1'b0;
        case (state)
            ST_IDLE: begin
                if (vsync_fall) state_nx = ST_ARMED;
            end
            ST_ARMED: begin
                if (vsync_rise) begin
                    state_nx = ST_REPORT;
                    rpt_fire = 1'b1;
                end else if (i_cmos_href_delay) begin
                    state_nx = ST_FRAME;
                end
            end
            ST_FRAME: begin
                if (vsync_rise) begin
                    state_nx = ST_REPORT;
                    rpt_fire = 1'b1;
                end
            end
            ST_REPORT: state_nx = ST_ARMED;
            default:   state_nx = ST_IDLE;
        endcase
    end

    logic [X_W-1:0]   acc_x_min, acc_x_max, nx_x_min, nx_x_max;
    logic [Y_W-1:0]   acc_y_min, acc_y_max, nx_y_min, nx_y_max;
    logic [CNT_W-1:0] acc_count, nx_count;
    logic             hit;
    assign hit = pk_vld & win_ok & acc_en;

    // Accumulator next value, so a pixel landing on the report edge is still included.
    always_comb begin
        nx_x_min = acc_x_min;
        nx_x_max = acc_x_max;
        nx_y_min = acc_y_min;
        nx_y_max = acc_y_max;
        nx_count = acc_count;
        if (hit) begin
            if (x_cnt < acc_x_min) nx_x_min = x_cnt;
            if (x_cnt > acc_x_max) nx_x_max = x_cnt;
            if (y_cnt < acc_y_min) nx_y_min = y_cnt;
            if (y_cnt > acc_y_max) nx_y_max = y_cnt;
            if (acc_count != '1)   nx_count = acc_count + CNT_W'(1);
        end
    end

    // Accumulator held empty outside a frame, which also clears it in the report cycle.
    always_ff @(posedge i_cmos_pclk_gbuf or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_x_min <= '1;
            acc_x_max <= '0;
            acc_y_min <= '1;
            acc_y_max <= '0;
            acc_count <= '0;
        end else if (!acc_en) begin
            acc_x_min <= '1;
            acc_x_max <= '0;
            acc_y_min <= '1;
            acc_y_max <= '0;
            acc_count <= '0;
        end else begin
            acc_x_min <= nx_x_min;
            acc_x_max <= nx_x_max;
            acc_y_min <= nx_y_min;
            acc_y_max <= nx_y_max;
            acc_count <= nx_count;
        end
    end

    box_rpt_t rpt_q;

    // Report latch; an empty frame reports an all-zero box.
    always_ff @(posedge i_cmos_pclk_gbuf or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rpt_q <= '0;
        end else if (rpt_fire) begin
            if (nx_count == '0) begin
                rpt_q <= '0;
            end else begin
                rpt_q.x_min <= BOX_XY_W'(nx_x_min);
                rpt_q.x_max <= BOX_XY_W'(nx_x_max);
                rpt_q.y_min <= BOX_XY_W'(nx_y_min);
                rpt_q.y_max <= BOX_XY_W'(nx_y_max);
                rpt_q.count <= BOX_CNT_W'(nx_count);
                rpt_q.found <= BOX_CNT_W'(nx_count) >= BOX_CNT_W'(MIN_COUNT);
            end
        end
    end

    assign o_box_valid = (state == ST_REPORT);
    assign o_x_min     = rpt_q.x_min[X_W-1:0];
    assign o_x_max     = rpt_q.x_max[X_W-1:0];
    assign o_y_min     = rpt_q.y_min[Y_W-1:0];
    assign o_y_max     = rpt_q.y_max[Y_W-1:0];
    assign o_count     = rpt_q.count[CNT_W-1:0];
    assign o_found     = rpt_q.found;

    // Report field bits above the instance widths are always zero; folded here so they count as read.
    logic unused_rpt_bits;
    assign unused_rpt_bits = ^rpt_q;

endmodule

// File: tb/tb_ot_color_box_tracker.sv
module tb_ot_color_box_tracker;
    import ot_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync, href;
    logic [7:0] d;
    logic [4:0] r_min, r_max, b_min, b_max;
    logic [5:0] g_min, g_max;

    always #5 clk = ~clk;

    // a_: default instance, b_: byte-swapped, c_: 4-bit saturating counter with MIN_COUNT=8
    logic        a_vsync, a_href, a_pix_en, a_mask, a_box_valid, a_found;
    logic [15:0] a_pix;
    logic [10:0] a_x, a_y, a_x_min, a_x_max, a_y_min, a_y_max;
    logic [19:0] a_count;
    logic        b_vsync, b_href, b_pix_en, b_mask, b_box_valid, b_found;
    logic [15:0] b_pix;
    logic [10:0] b_x, b_y, b_x_min, b_x_max, b_y_min, b_y_max;
    logic [19:0] b_count;
    logic        c_vsync, c_href, c_pix_en, c_mask, c_box_valid, c_found;
    logic [15:0] c_pix;
    logic [10:0] c_x, c_y, c_x_min, c_x_max, c_y_min, c_y_max;
    logic [3:0]  c_count;

    ot_color_box_tracker u_dut_a (
        .i_cmos_pclk_gbuf(clk), .i_rst_n(rst_n), .i_cmos_vsync_delay(vsync),
        .i_cmos_href_delay(href), .i_cmos_d_delay(d),
        .i_r_min(r_min), .i_r_max(r_max), .i_g_min(g_min), .i_g_max(g_max),
        .i_b_min(b_min), .i_b_max(b_max),
        .o_vsync(a_vsync), .o_href(a_href), .o_pix(a_pix), .o_pix_en(a_pix_en),
        .o_mask(a_mask), .o_x(a_x), .o_y(a_y), .o_box_valid(a_box_valid),
        .o_x_min(a_x_min), .o_x_max(a_x_max), .o_y_min(a_y_min), .o_y_max(a_y_max),
        .o_count(a_count), .o_found(a_found)
    );

    ot_color_box_tracker #(.BYTE_SWAP(1)) u_dut_b (
        .i_cmos_pclk_gbuf(clk), .i_rst_n(rst_n), .i_cmos_vsync_delay(vsync),
        .i_cmos_href_delay(href), .i_cmos_d_delay(d),
        .i_r_min(r_min), .i_r_max(r_max), .i_g_min(g_min), .i_g_max(g_max),
        .i_b_min(b_min), .i_b_max(b_max),
        .o_vsync(b_vsync), .o_href(b_href), .o_pix(b_pix), .o_pix_en(b_pix_en),
        .o_mask(b_mask), .o_x(b_x), .o_y(b_y), .o_box_valid(b_box_valid),
        .o_x_min(b_x_min), .o_x_max(b_x_max), .o_y_min(b_y_min), .o_y_max(b_y_max),
        .o_count(b_count), .o_found(b_found)
    );

    ot_color_box_tracker #(.CNT_W(4), .MIN_COUNT(8)) u_dut_c (
        .i_cmos_pclk_gbuf(clk), .i_rst_n(rst_n), .i_cmos_vsync_delay(vsync),
        .i_cmos_href_delay(href), .i_cmos_d_delay(d),
        .i_r_min(r_min), .i_r_max(r_max), .i_g_min(g_min), .i_g_max(g_max),
        .i_b_min(b_min), .i_b_max(b_max),
        .o_vsync(c_vsync), .o_href(c_href), .o_pix(c_pix), .o_pix_en(c_pix_en),
        .o_mask(c_mask), .o_x(c_x), .o_y(c_y), .o_box_valid(c_box_valid),
        .o_x_min(c_x_min), .o_x_max(c_x_max), .o_y_min(c_y_min), .o_y_max(c_y_max),
        .o_count(c_count), .o_found(c_found)
    );

    // Pixel/report capture, sampled on the falling edge away from the active edge.
    logic [15:0] a_pix_q[$];
    logic        a_mask_q[$];
    int          a_x_q[$];
    int          a_y_q[$];
    logic [15:0] b_pix_q[$];
    logic        b_mask_q[$];
    int          a_rpts = 0;
    int          b_rpts = 0;
    int          c_rpts = 0;

    always @(negedge clk) begin
        if (a_pix_en) begin
            a_pix_q.push_back(a_pix);
            a_mask_q.push_back(a_mask);
            a_x_q.push_back(int'(a_x));
            a_y_q.push_back(int'(a_y));
        end
        if (b_pix_en) begin
            b_pix_q.push_back(b_pix);
            b_mask_q.push_back(b_mask);
        end
        if (a_box_valid) a_rpts++;
        if (b_box_valid) b_rpts++;
        if (c_box_valid) c_rpts++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_win(input logic [4:0] r0, input logic [4:0] r1, input logic [5:0] g0,
                           input logic [5:0] g1, input logic [4:0] b0, input logic [4:0] b1);
        r_min = r0; r_max = r1; g_min = g0; g_max = g1; b_min = b0; b_max = b1;
    endtask

    // Vertical blanking pulse: rising edge ends a frame, falling edge starts the next.
    task automatic vs_pulse();
        href  = 1'b0;
        vsync = 1'b1;
        repeat (4) tick();
        vsync = 1'b0;
        repeat (4) tick();
    endtask

    task automatic send_line(input int nbytes, input logic [7:0] b0, input logic [7:0] b1);
        href = 1'b1;
        for (int i = 0; i < nbytes; i++) begin
            d = (i % 2 == 0) ? b0 : b1;
            tick();
        end
        href = 1'b0;
        d    = 8'h00;
        repeat (4) tick();
    endtask

    int base_a, base_b, ra, rb, rc, msum, exp_x, exp_y;

    initial begin
        vsync = 1'b1; href = 1'b0; d = 8'h00;
        set_win(5'd31, 5'd31, 6'd0, 6'd0, 5'd0, 5'd0);
        repeat (3) tick();

        // Reset state
        chk("rst_pix", 32'(a_pix), 32'h0);
        chk("rst_pix_en", 32'(a_pix_en), 32'h0);
        chk("rst_vsync", 32'(a_vsync), 32'h0);
        chk("rst_box_valid", 32'(a_box_valid), 32'h0);
        chk("rst_count", 32'(a_count), 32'h0);

        rst_n = 1'b1;
        tick();
        vs_pulse();

        // Test 1: 4x2 frame of 0xF8,0x00 pixels against a pure-red window
        base_a = a_pix_q.size(); base_b = b_pix_q.size();
        ra = a_rpts; rb = b_rpts; rc = c_rpts;
        send_line(8, 8'hF8, 8'h00);
        send_line(8, 8'hF8, 8'h00);
        vs_pulse();
        chk("t1_npix", 32'(a_pix_q.size() - base_a), 32'd8);
        for (int i = 0; i < a_pix_q.size() - base_a; i++) begin
            chk("t1_pix", 32'(a_pix_q[base_a+i]), 32'hF800);
            chk("t1_mask", 32'(a_mask_q[base_a+i]), 32'h1);
            chk("t1_x", 32'(a_x_q[base_a+i]), 32'(i % 4));
            chk("t1_y", 32'(a_y_q[base_a+i]), 32'(i / 4));
        end
        chk("t1_nrpt", 32'(a_rpts - ra), 32'd1);
        chk("t1_x_min", 32'(a_x_min), 32'd0);
        chk("t1_x_max", 32'(a_x_max), 32'd3);
        chk("t1_y_min", 32'(a_y_min), 32'd0);
        chk("t1_y_max", 32'(a_y_max), 32'd1);
        chk("t1_count", 32'(a_count), 32'd8);
        chk("t1_found", 32'(a_found), 32'd0);
        // Byte-swapped instance sees 0x00F8, outside the window
        chk("t1s_npix", 32'(b_pix_q.size() - base_b), 32'd8);
        msum = 0;
        for (int i = base_b; i < b_pix_q.size(); i++) begin
            chk("t1s_pix", 32'(b_pix_q[i]), 32'h00F8);
            msum += int'(b_mask_q[i]);
        end
        chk("t1s_masks", 32'(msum), 32'd0);
        chk("t1s_nrpt", 32'(b_rpts - rb), 32'd1);
        chk("t1s_count", 32'(b_count), 32'd0);
        chk("t1s_x_max", 32'(b_x_max), 32'd0);
        chk("t1s_y_max", 32'(b_y_max), 32'd0);
        chk("t1s_found", 32'(b_found), 32'd0);
        // MIN_COUNT=8 instance: 8 matches is enough
        chk("t1c_nrpt", 32'(c_rpts - rc), 32'd1);
        chk("t1c_count", 32'(c_count), 32'd8);
        chk("t1c_found", 32'(c_found), 32'd1);

        // Test 2: 7-byte line gives three pixels, trailing byte dropped, one row advance
        base_a = a_pix_q.size();
        send_line(7, 8'hF8, 8'h00);
        send_line(2, 8'hF8, 8'h00);
        vs_pulse();
        chk("t2_npix", 32'(a_pix_q.size() - base_a), 32'd4);
        for (int i = 0; i < a_pix_q.size() - base_a; i++) begin
            exp_x = (i < 3) ? i : 0;
            exp_y = (i < 3) ? 0 : 1;
            chk("t2_x", 32'(a_x_q[base_a+i]), 32'(exp_x));
            chk("t2_y", 32'(a_y_q[base_a+i]), 32'(exp_y));
        end
        chk("t2_count", 32'(a_count), 32'd4);
        chk("t2_x_max", 32'(a_x_max), 32'd2);
        chk("t2_y_max", 32'(a_y_max), 32'd1);

        // Test 3: window changed mid-frame only takes effect next frame
        base_a = a_pix_q.size();
        send_line(4, 8'hF8, 8'h00);
        set_win(5'd0, 5'd0, 6'd0, 6'd0, 5'd0, 5'd0);
        send_line(4, 8'hF8, 8'h00);
        vs_pulse();
        msum = 0;
        for (int i = base_a; i < a_pix_q.size(); i++) msum += int'(a_mask_q[i]);
        chk("t3_masks_old_win", 32'(msum), 32'd4);
        chk("t3_count_old_win", 32'(a_count), 32'd4);
        base_a = a_pix_q.size();
        ra = a_rpts;
        send_line(4, 8'hF8, 8'h00);
        vs_pulse();
        msum = 0;
        for (int i = base_a; i < a_pix_q.size(); i++) msum += int'(a_mask_q[i]);
        chk("t3_masks_new_win", 32'(msum), 32'd0);
        chk("t3_nrpt", 32'(a_rpts - ra), 32'd1);
        chk("t3_count_new_win", 32'(a_count), 32'd0);
        chk("t3_x_min_empty", 32'(a_x_min), 32'd0);
        chk("t3_found_empty", 32'(a_found), 32'd0);

        // Test 4: reset mid-frame clears everything; first blanking after release does not report
        set_win(5'd31, 5'd31, 6'd0, 6'd0, 5'd0, 5'd0);
        vs_pulse();
        send_line(4, 8'hF8, 8'h00);
        href = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d = (i % 2 == 0) ? 8'hF8 : 8'h00;
            tick();
        end
        rst_n = 1'b0;
        #2;
        chk("t4_rst_pix", 32'(a_pix), 32'h0);
        chk("t4_rst_pix_en", 32'(a_pix_en), 32'h0);
        chk("t4_rst_href", 32'(a_href), 32'h0);
        chk("t4_rst_x", 32'(a_x), 32'h0);
        chk("t4_rst_box_valid", 32'(a_box_valid), 32'h0);
        href = 1'b0;
        d    = 8'h00;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        ra = a_rpts;
        send_line(4, 8'hF8, 8'h00);
        vs_pulse();
        chk("t4_no_report_partial", 32'(a_rpts - ra), 32'd0);
        send_line(4, 8'hF8, 8'h00);
        send_line(4, 8'hF8, 8'h00);
        vs_pulse();
        chk("t4_nrpt_full", 32'(a_rpts - ra), 32'd1);
        chk("t4_count", 32'(a_count), 32'd4);
        chk("t4_x_max", 32'(a_x_max), 32'd1);
        chk("t4_y_max", 32'(a_y_max), 32'd1);

        // Test 5: 21 matches saturate a 4-bit counter
        send_line(42, 8'hF8, 8'h00);
        vs_pulse();
        chk("t5c_count_sat", 32'(c_count), 32'd15);
        chk("t5c_found", 32'(c_found), 32'd1);
        chk("t5c_x_max", 32'(c_x_max), 32'd20);
        chk("t5_count", 32'(a_count), 32'd21);
        chk("t5_found", 32'(a_found), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
